// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg                                                            |
// | Shared widths and the queue entry type for the instruction fetcher.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int ADDR_W      = 64;
  localparam int INSTR_W     = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] inst;
  } fetch_entry_t;
endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo                                                           |
// | Flip-flop prefetch queue with push/pop/flush and occupancy count.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_pop;
  logic            w_do_push;

  // Guards keep the count inside 0..DEPTH even if a caller misbehaves.
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != C_DEPTH) || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch                                                          |
// | Sequential PC fetch from a combinational ROM into a prefetch queue.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int MEM_SIZE = 1024,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_inst,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   inst_valid,
  output logic [INSTR_W-1:0]     inst,
  output logic [ADDR_W-1:0]      inst_pc,
  input  logic                   inst_ready,
  output logic                   fetch_fault,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     C_DEPTH    = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] C_MEM_SIZE = ADDR_W'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] C_STEP     = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] C_LAST     = ADDR_W'(INSTR_BYTES - 1);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_fetch_fault;
  logic [ADDR_W-1:0] w_last_byte;
  logic              w_legal;
  logic              w_pop;
  logic              w_fetch;
  logic [CW-1:0]     w_count;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  // An aligned PC cannot wrap when the last byte offset is added.
  assign w_last_byte = r_fetch_pc + C_LAST;
  assign w_legal     = (r_fetch_pc[1:0] == 2'b00) && (w_last_byte < C_MEM_SIZE);

  assign inst_valid = (w_count != '0);
  assign w_pop      = inst_valid && inst_ready && !redirect;
  assign w_fetch    = !r_fetch_fault && !redirect && w_legal &&
                      ((w_count != C_DEPTH) || w_pop);

  assign w_push_entry.pc   = r_fetch_pc;
  assign w_push_entry.inst = imem_inst;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= '0;
      r_fetch_fault <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc    <= redirect_pc;
      r_fetch_fault <= 1'b0;
    end else begin
      if (w_fetch) r_fetch_pc <= r_fetch_pc + C_STEP;
      if (!w_legal) r_fetch_fault <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (w_fetch),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  assign imem_addr   = r_fetch_pc;
  assign inst        = w_head.inst;
  assign inst_pc     = w_head.pc;
  assign fetch_fault = r_fetch_fault;
  assign occupancy   = w_count;
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch                                                       |
// | Directed and random stimulus against a queue-based reference model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instr_fetch;
  localparam int MEM_SIZE = 1024;
  localparam int DEPTH    = 4;
  localparam int WORDS    = MEM_SIZE / 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        fetch_fault;
  logic [2:0]  occupancy;

  logic [31:0] rom [WORDS];

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_pc    = '0;
  logic        m_fault = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign imem_inst = rom[imem_addr[9:2]];

  instr_fetch #(
    .MEM_SIZE (MEM_SIZE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_inst   (imem_inst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .fetch_fault (fetch_fault),
    .occupancy   (occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // One clock: apply inputs, compare outputs at negedge, then advance the model.
  task automatic step(input logic rst, input logic rdr, input logic [63:0] rpc, input logic rdy);
    logic legal;
    logic do_pop;
    ent_t e;
    reset       = rst;
    redirect    = rdr;
    redirect_pc = rpc;
    inst_ready  = rdy;
    @(negedge clk);
    check("valid", 64'(inst_valid), 64'(m_q.size() != 0));
    check("occupancy", 64'(occupancy), 64'(m_q.size()));
    check("fault", 64'(fetch_fault), 64'(m_fault));
    check("imem_addr", imem_addr, m_pc);
    if (m_q.size() != 0) begin
      check("inst_pc", inst_pc, m_q[0].pc);
      check("inst", 64'(inst), 64'(m_q[0].inst));
    end
    if (rst) begin
      m_q.delete();
      m_pc    = '0;
      m_fault = 1'b0;
    end else if (rdr) begin
      m_q.delete();
      m_pc    = rpc;
      m_fault = 1'b0;
    end else begin
      legal  = (m_pc % 4 == 0) && (m_pc < 64'(MEM_SIZE - 3));
      do_pop = (m_q.size() != 0) && rdy;
      if (do_pop) void'(m_q.pop_front());
      if (!m_fault && legal && m_q.size() < DEPTH) begin
        e.pc   = m_pc;
        e.inst = rom[m_pc / 4];
        m_q.push_back(e);
        m_pc = m_pc + 64'd4;
      end
      if (!m_fault && !legal) m_fault = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pick_target();
    case ($urandom % 5)
      0:       return 64'($urandom_range(0, WORDS - 1)) * 64'd4;
      1:       return 64'($urandom_range(0, MEM_SIZE - 1)) | 64'd1;
      2:       return 64'(MEM_SIZE) - 64'd4 * 64'($urandom_range(1, 6));
      3:       return 64'hFFFF_FFFF_FFFF_FFFC;
      default: return 64'(MEM_SIZE) + 64'd4 * 64'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < WORDS; i++) rom[i] = $urandom;

    // Reset with a redirect pending, then free-running fetch.
    step(1'b1, 1'b1, 64'h80, 1'b1);
    step(1'b1, 1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

    // Back-pressure fills the queue, then a simultaneous push and pop.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b0);

    // Redirect with a partially filled queue.
    step(1'b1, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b0, 1'b1, 64'h40, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

    // Run off the end of memory, then recover.
    step(1'b0, 1'b1, 64'd1008, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 1'b1, 64'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

    // Misaligned target.
    step(1'b0, 1'b1, 64'h42, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

    // Reset beats a full queue and a simultaneous redirect.
    step(1'b0, 1'b1, 64'h100, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b1, 1'b1, 64'h200, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 250) == 0, ($urandom % 16) == 0, pick_target(), ($urandom % 4) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter MEM_SIZE, 1024, instruction memory size in bytes; power of two, >4.
REQ-002 Parameter DEPTH, 4, prefetch queue entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  64  byte address driven to the combinational instruction ROM.
REQ-006 imem_inst  input  32  instruction word returned by the ROM in the same cycle.
REQ-007 redirect  input  1  branch/jump taken; flush and restart at redirect_pc.
REQ-008 redirect_pc  input  64  byte address of the new fetch target.
REQ-009 inst_valid  output  1  queue head holds a valid instruction.
REQ-010 inst  output  32  instruction at queue head.
REQ-011 inst_pc  output  64  byte address of the instruction at queue head.
REQ-012 inst_ready  input  1  decoder accepts the head this cycle.
REQ-013 fetch_fault  output  1  sticky; fetch stopped on a misaligned or out-of-bounds PC.
REQ-014 occupancy  output  $clog2(DEPTH)+1  current queue entry count.

Function
REQ-015 fetch_pc register drives imem_addr directly; no combinational path from any input to imem_addr.
REQ-016 Fetch condition: !fetch_fault && !redirect && (count < DEPTH || pop) && fetch_pc legal.
REQ-017 Legal PC: fetch_pc[1:0]==0 and fetch_pc+3 < MEM_SIZE.
REQ-018 On fetch: push {fetch_pc, imem_inst} to queue tail; fetch_pc <= fetch_pc+4 (64-bit wrapping add).
REQ-019 Pop when inst_valid && inst_ready && !redirect; head advances by one.
REQ-020 Push and pop in the same cycle, queue full: both occur; count unchanged.
REQ-021 Push and pop in the same cycle, queue empty: not a bypass; new entry visible on inst_valid the next cycle.
REQ-022 Fetch-to-valid latency: 1 cycle (instruction fetched in cycle N is at head, if queue was empty, in cycle N+1).
REQ-023 Redirect (highest priority): queue cleared, count <= 0, fetch_pc <= redirect_pc, fetch_fault <= 0, no push and no pop that cycle.
REQ-024 fetch_pc illegal while no redirect: no push, fetch_fault <= 1 next cycle; remains 1 until redirect or reset.
REQ-025 Entries queued before a fault remain poppable; inst_valid follows count only.
REQ-026 inst and inst_pc are don't-care when inst_valid==0; inst_valid == (count != 0).
REQ-027 Read and write pointers wrap modulo DEPTH; count never exceeds DEPTH or goes below 0.
REQ-028 Throughput: with inst_ready held high, one instruction delivered per cycle steady state.

Reset
REQ-029 On reset: fetch_pc=0, count=0, pointers=0, fetch_fault=0, inst_valid=0, occupancy=0.
REQ-030 Reset overrides redirect and all handshakes; in-flight entries are discarded.
REQ-031 First fetch (address 0) occurs in the first cycle after reset deasserts.

Structure
REQ-032 Shared package fetch_pkg holds INSTR_BYTES=4, ADDR_W=64, INSTR_W=32 and typedef fetch_entry_t {pc[63:0], inst[31:0]}.
REQ-033 Queue is a sub-module fetch_fifo (parameter DEPTH, push/pop/flush, fetch_entry_t data, count); instr_fetch holds PC and fault logic.
REQ-034 Queue storage is flip-flops; no memory macros.

Verification
REQ-035 Reset, inst_ready=1, ROM holding 4 known words -> inst_pc 0,4,8,12 on consecutive cycles, inst_valid first high in cycle 2 after reset.
REQ-036 inst_ready=0 for 10 cycles -> occupancy saturates at 4, imem_addr holds 16; ready asserted -> pc 0 popped, fetch at 16 same cycle, occupancy stays 4.
REQ-037 Redirect to 0x40 with 3 entries queued -> next cycle occupancy 0, inst_valid 0; following cycle inst_pc=0x40.
REQ-038 Sequential fetch reaching 1020 (MEM_SIZE=1024) -> entry 1020 pushed, fetch_pc 1024, fetch_fault=1 next cycle, no further pushes; redirect to 0 clears fault.
REQ-039 Redirect to 0x42 -> no push, fetch_fault=1 next cycle, occupancy 0.
REQ-040 Reset asserted with full queue and pending redirect -> all outputs at reset values next cycle; fetching resumes at 0.
